// File: rtl/ita_package.sv
// Shared ITA types: controller steps, counters, requantizer output word and output-buffer tags.
package ita_package;

    localparam int unsigned N = 16;
    localparam int unsigned M = 64;
    localparam int unsigned CounterWidth = 16;

    typedef logic [CounterWidth-1:0] counter_t;

    typedef enum logic [3:0] {
        Idle, Q, K, V, QK, AV, OW, F1, F2, MatmulOnly
    } step_e;

    typedef logic [N-1:0][7:0] requant_oup_t;

    typedef struct packed {
        step_e    step;
        counter_t tile_x;
        counter_t tile_y;
        counter_t word;
        logic     last;
    } oup_tag_t;

endpackage

// File: rtl/ita_fifo.sv
// Generic synchronous FIFO with registered storage, wrap-around pointers and a synchronous flush.
module ita_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [Width-1:0]           data_i,
    output logic [Width-1:0]           data_o,
    output logic [$clog2(Depth+1)-1:0] fill_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PtrW  = $clog2(Depth);
    localparam int unsigned FillW = $clog2(Depth+1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [FillW-1:0] fill;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (fill == FillW'(Depth));
    assign empty_o = (fill == '0);
    assign fill_o  = fill;
    assign data_o  = empty_o ? '0 : mem[rd_ptr];

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && !clear_i && do_push) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/ita_oup_buffer.sv
// Output buffer between requantizer and streamer: masks padding lanes, tags words with step/tile/word index.
// Handshake: a word moves on a side when valid and ready are both high at the rising edge; valid never waits on ready.
module ita_oup_buffer
    import ita_package::*;
#(
    parameter int unsigned N     = ita_package::N,
    parameter int unsigned M     = ita_package::M,
    parameter int unsigned Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       oup_valid_i,
    output logic                       oup_ready_o,
    input  logic [N*8-1:0]             oup_data_i,
    input  logic [N-1:0]               oup_mask_i,
    input  step_e                      step_i,
    input  counter_t                   tile_x_i,
    input  counter_t                   tile_y_i,
    input  logic                       clear_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [N*8-1:0]             out_data_o,
    output step_e                      out_step_o,
    output counter_t                   out_tile_x_o,
    output counter_t                   out_tile_y_o,
    output counter_t                   out_word_o,
    output logic                       out_last_o,
    output logic [$clog2(Depth+1)-1:0] fill_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned WordsPerTile = M * M / N;
    localparam counter_t    LastWord     = counter_t'(WordsPerTile - 1);
    localparam int unsigned EntryW       = N * 8 + $bits(oup_tag_t);

    logic             push;
    logic             pop;
    logic [N*8-1:0]   masked_data;
    oup_tag_t         push_tag;
    oup_tag_t         head_tag;
    counter_t         word_cnt;
    counter_t         word_now;
    step_e            prev_step;
    logic [EntryW-1:0] head_entry;

    assign oup_ready_o = !full_o || out_ready_i;
    assign out_valid_o = !empty_o;
    assign push        = oup_valid_i && oup_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    always_comb begin
        masked_data = '0;
        for (int i = 0; i < int'(N); i++) begin
            masked_data[i*8 +: 8] = oup_mask_i[i] ? oup_data_i[i*8 +: 8] : 8'h00;
        end
    end

    // A new step restarts word numbering even mid-tile.
    assign word_now = (step_i != prev_step) ? '0 : word_cnt;

    always_comb begin
        push_tag        = '0;
        push_tag.step   = step_i;
        push_tag.tile_x = tile_x_i;
        push_tag.tile_y = tile_y_i;
        push_tag.word   = word_now;
        push_tag.last   = (word_now == LastWord);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            word_cnt  <= '0;
            prev_step <= Idle;
        end else if (push) begin
            word_cnt  <= push_tag.last ? '0 : word_now + 1'b1;
            prev_step <= step_i;
        end
    end

    ita_fifo #(
        .Width (EntryW),
        .Depth (Depth)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  ({masked_data, push_tag}),
        .data_o  (head_entry),
        .fill_o  (fill_o),
        .full_o  (full_o),
        .empty_o (empty_o)
    );

    assign {out_data_o, head_tag} = head_entry;
    assign out_step_o   = head_tag.step;
    assign out_tile_x_o = head_tag.tile_x;
    assign out_tile_y_o = head_tag.tile_y;
    assign out_word_o   = head_tag.word;
    assign out_last_o   = head_tag.last;

endmodule

// File: tb/tb_ita_oup_buffer.sv
// Directed bench for ita_oup_buffer: full/backpressure, masking, word numbering, clear and reset.
module tb_ita_oup_buffer;
    import ita_package::*;

    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [127:0] d;
        step_e        s;
        counter_t     tx;
        counter_t     ty;
        counter_t     w;
        logic         l;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          oup_valid_i = 1'b0;
    logic          oup_ready_o;
    logic [127:0]  oup_data_i = '0;
    logic [15:0]   oup_mask_i = '1;
    step_e         step_i = Idle;
    counter_t      tile_x_i = '0;
    counter_t      tile_y_i = '0;
    logic          clear_i = 1'b0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [127:0]  out_data_o;
    step_e         out_step_o;
    counter_t      out_tile_x_o;
    counter_t      out_tile_y_o;
    counter_t      out_word_o;
    logic          out_last_o;
    logic [2:0]    fill_o;
    logic          full_o;
    logic          empty_o;

    int n_checks = 0;
    int n_err    = 0;
    exp_t exp_q[$];

    ita_oup_buffer #(.N(16), .M(64), .Depth(DEPTH)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .oup_valid_i  (oup_valid_i),
        .oup_ready_o  (oup_ready_o),
        .oup_data_i   (oup_data_i),
        .oup_mask_i   (oup_mask_i),
        .step_i       (step_i),
        .tile_x_i     (tile_x_i),
        .tile_y_i     (tile_y_i),
        .clear_i      (clear_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .out_step_o   (out_step_o),
        .out_tile_x_o (out_tile_x_o),
        .out_tile_y_o (out_tile_y_o),
        .out_word_o   (out_word_o),
        .out_last_o   (out_last_o),
        .fill_o       (fill_o),
        .full_o       (full_o),
        .empty_o      (empty_o)
    );

    // clock
    always #5 clk_i = ~clk_i;

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_fill"},  128'(fill_o), 128'(0));
        chk({tag, "_empty"}, 128'(empty_o), 128'(1));
        chk({tag, "_full"},  128'(full_o), 128'(0));
        chk({tag, "_valid"}, 128'(out_valid_o), 128'(0));
        chk({tag, "_data"},  out_data_o, 128'(0));
        chk({tag, "_step"},  128'(out_step_o), 128'(0));
        chk({tag, "_tx"},    128'(out_tile_x_o), 128'(0));
        chk({tag, "_ty"},    128'(out_tile_y_o), 128'(0));
        chk({tag, "_word"},  128'(out_word_o), 128'(0));
        chk({tag, "_last"},  128'(out_last_o), 128'(0));
        chk({tag, "_ready"}, 128'(oup_ready_o), 128'(1));
    endtask

    // One clock of traffic: check head and ready against the model, clock, update model, check occupancy.
    task automatic xfer(input logic v, input logic r, input logic [127:0] d, input logic [127:0] exp_d,
                        input logic [15:0] mask, input step_e s, input counter_t tx, input counter_t ty,
                        input counter_t w);
        exp_t e;
        logic do_push;
        logic do_pop;
        oup_valid_i = v;
        out_ready_i = r;
        oup_data_i  = d;
        oup_mask_i  = mask;
        step_i      = s;
        tile_x_i    = tx;
        tile_y_i    = ty;
        #1;
        chk("oup_ready", 128'(oup_ready_o), 128'((exp_q.size() < DEPTH) || r));
        if (exp_q.size() > 0) begin
            chk("out_valid", 128'(out_valid_o), 128'(1));
            chk("out_data",  out_data_o, exp_q[0].d);
            chk("out_step",  128'(out_step_o), 128'(exp_q[0].s));
            chk("out_tx",    128'(out_tile_x_o), 128'(exp_q[0].tx));
            chk("out_ty",    128'(out_tile_y_o), 128'(exp_q[0].ty));
            chk("out_word",  128'(out_word_o), 128'(exp_q[0].w));
            chk("out_last",  128'(out_last_o), 128'(exp_q[0].l));
        end else begin
            chk("out_valid_empty", 128'(out_valid_o), 128'(0));
            chk("out_data_empty",  out_data_o, 128'(0));
        end
        do_pop  = r && (exp_q.size() > 0);
        do_push = v && ((exp_q.size() < DEPTH) || r);
        cyc();
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) begin
            e.d = exp_d; e.s = s; e.tx = tx; e.ty = ty; e.w = w; e.l = (w == 16'd255);
            exp_q.push_back(e);
        end
        chk("fill",  128'(fill_o), 128'(exp_q.size()));
        chk("full",  128'(full_o), 128'(exp_q.size() == DEPTH));
        chk("empty", 128'(empty_o), 128'(exp_q.size() == 0));
    endtask

    function automatic logic [127:0] pat(input int k);
        logic [15:0] h;
        h = 16'h5A00 ^ 16'(k);
        return {8{h}};
    endfunction

    initial begin
        logic [127:0] aa;
        logic [127:0] aa_masked;
        aa        = {16{8'hAA}};
        aa_masked = {64'h0, {8{8'hAA}}};

        // reset
        rst_i = 1'b1;
        cyc();
        cyc();
        chk_reset("reset");
        rst_i = 1'b0;
        cyc();
        chk_reset("post_reset");

        // fill to full with backpressure, 5th offered word must be refused
        for (int k = 0; k < 4; k++) xfer(1, 0, pat(k), pat(k), '1, QK, 16'd1, 16'd2, counter_t'(k));
        chk("full_after4", 128'(full_o), 128'(1));
        chk("ready_full",  128'(oup_ready_o), 128'(0));
        xfer(1, 0, pat(99), pat(99), '1, QK, 16'd1, 16'd2, 16'd4);

        // full with streaming on both sides: occupancy stays at Depth, order preserved
        for (int k = 4; k < 14; k++) xfer(1, 1, pat(k), pat(k), '1, QK, 16'd3, 16'd4, counter_t'(k));
        for (int k = 0; k < 4; k++) xfer(0, 1, '0, '0, '1, QK, '0, '0, '0);
        xfer(0, 0, '0, '0, '1, QK, '0, '0, '0);

        // lane masking, step change to AV restarts word index
        xfer(1, 0, aa, aa_masked, 16'h00FF, AV, 16'd7, 16'd8, 16'd0);
        xfer(0, 1, '0, '0, '1, AV, '0, '0, '0);
        xfer(0, 0, '0, '0, '1, AV, '0, '0, '0);

        // a full tile plus one in QK, then a step change
        for (int k = 0; k < 257; k++)
            xfer(1, 1, pat(k), pat(k), '1, QK, counter_t'(k % 5), counter_t'(k % 3), counter_t'(k % 256));
        xfer(1, 1, pat(300), pat(300), '1, AV, 16'd9, 16'd9, 16'd0);
        xfer(0, 1, '0, '0, '1, AV, '0, '0, '0);
        xfer(0, 1, '0, '0, '1, AV, '0, '0, '0);
        xfer(0, 0, '0, '0, '1, AV, '0, '0, '0);

        // clear with fill 3 and a simultaneous push
        for (int k = 1; k < 4; k++) xfer(1, 0, pat(400 + k), pat(400 + k), '1, AV, 16'd2, 16'd2, counter_t'(k));
        clear_i     = 1'b1;
        oup_valid_i = 1'b1;
        oup_data_i  = pat(500);
        cyc();
        clear_i     = 1'b0;
        oup_valid_i = 1'b0;
        exp_q.delete();
        chk("clear_fill",  128'(fill_o), 128'(0));
        chk("clear_empty", 128'(empty_o), 128'(1));
        chk("clear_valid", 128'(out_valid_o), 128'(0));
        chk("clear_data",  out_data_o, 128'(0));
        xfer(1, 0, pat(501), pat(501), '1, AV, 16'd1, 16'd1, 16'd0);
        xfer(0, 1, '0, '0, '1, AV, '0, '0, '0);
        xfer(0, 0, '0, '0, '1, AV, '0, '0, '0);

        // reset wins over clear with fill 2
        xfer(1, 0, pat(600), pat(600), '1, Q, 16'd5, 16'd6, 16'd0);
        xfer(1, 0, pat(601), pat(601), '1, Q, 16'd5, 16'd6, 16'd1);
        rst_i       = 1'b1;
        clear_i     = 1'b1;
        oup_valid_i = 1'b1;
        out_ready_i = 1'b1;
        cyc();
        chk_reset("rst_clear");
        rst_i       = 1'b0;
        clear_i     = 1'b0;
        oup_valid_i = 1'b0;
        out_ready_i = 1'b0;
        exp_q.delete();
        cyc();
        chk_reset("rst_after");
        xfer(1, 0, pat(700), pat(700), '1, Q, 16'd1, 16'd0, 16'd0);
        xfer(0, 1, '0, '0, '1, Q, '0, '0, '0);
        xfer(0, 0, '0, '0, '1, Q, '0, '0, '0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
